// File: rtl/dm_wb_pkg.sv
// Shared types and widths for the data-memory / writeback stage.
package dm_wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

endpackage

// File: rtl/dm_timeout_cnt.sv
// Access timeout counter: cleared on access entry, counts unacknowledged cycles,
// flags expiry when the count reaches LIMIT-1.
module dm_timeout_cnt
    import dm_wb_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/dm_wb_stage.sv
// Data-memory / writeback pipeline stage with handshaked memory port and timeout.
// Optional build macro DM_MISALIGN_CHECK_EN rejects word-misaligned memory ops.
module dm_wb_stage
    import dm_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  mem_to_reg_in,
    input  logic                  reg_write_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [XLEN-1:0]       mem_address_in,
    input  logic [XLEN-1:0]       write_data_in,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  stall,
    output logic [XLEN-1:0]       read_data_out,
    output logic [XLEN-1:0]       alu_result_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  mem_to_reg_out,
    output logic                  reg_write_out,
    output logic                  mem_err_out
);

    state_e                state_q, state_d;
    logic                  req_q, req_d, we_q, we_d;
    logic [XLEN-1:0]       addr_q, addr_d, wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] rd_lat_q, rd_lat_d;
    logic                  rd_en_lat_q, rd_en_lat_d;
    logic                  mtr_lat_q, mtr_lat_d;
    logic                  rw_lat_q, rw_lat_d;
    logic [XLEN-1:0]       rdata_q, rdata_d, alu_q, alu_d;
    logic [REG_ADDR_W-1:0] rd_out_q, rd_out_d;
    logic                  mtr_out_q, mtr_out_d;
    logic                  rw_out_q, rw_out_d;
    logic                  err_q, err_d;
    logic                  stall_raw, cnt_clear, cnt_en, expired;
    logic                  one_op, both_ops, misalign;

    assign one_op   = mem_read_in ^ mem_write_in;
    assign both_ops = mem_read_in & mem_write_in;

`ifdef DM_MISALIGN_CHECK_EN
    assign misalign = |mem_address_in[1:0];
`else
    assign misalign = 1'b0;
`endif

    dm_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_lat_d    = rd_lat_q;
        rd_en_lat_d = rd_en_lat_q;
        mtr_lat_d   = mtr_lat_q;
        rw_lat_d    = rw_lat_q;
        rdata_d     = rdata_q;
        alu_d       = alu_q;
        rd_out_d    = rd_out_q;
        mtr_out_d   = mtr_out_q;
        rw_out_d    = 1'b0;   // bubble unless an instruction retires this edge
        err_d       = 1'b0;
        stall_raw   = 1'b0;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (both_ops || (one_op && misalign)) begin
                    alu_d     = mem_address_in;
                    rd_out_d  = rd_in;
                    mtr_out_d = mem_to_reg_in;
                    rdata_d   = '0;
                    err_d     = 1'b1;
                end else if (one_op) begin
                    stall_raw   = 1'b1;
                    addr_d      = mem_address_in;
                    wdata_d     = write_data_in;
                    rd_lat_d    = rd_in;
                    rd_en_lat_d = mem_read_in;
                    mtr_lat_d   = mem_to_reg_in;
                    rw_lat_d    = reg_write_in;
                    req_d       = 1'b1;
                    we_d        = mem_write_in;
                    cnt_clear   = 1'b1;
                    state_d     = ACCESS;
                end else begin
                    alu_d     = mem_address_in;
                    rd_out_d  = rd_in;
                    mtr_out_d = mem_to_reg_in;
                    rw_out_d  = reg_write_in;
                    rdata_d   = '0;
                end
            end
            ACCESS: begin
                // Ack is checked before expiry so a last-cycle ack still retires normally.
                if (dmem_ack) begin
                    rdata_d   = rd_en_lat_q ? dmem_rdata : '0;
                    alu_d     = addr_q;
                    rd_out_d  = rd_lat_q;
                    mtr_out_d = mtr_lat_q;
                    rw_out_d  = rw_lat_q;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    state_d   = IDLE;
                end else if (expired) begin
                    rdata_d   = '0;
                    alu_d     = addr_q;
                    rd_out_d  = rd_lat_q;
                    mtr_out_d = mtr_lat_q;
                    err_d     = 1'b1;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    state_d   = IDLE;
                end else begin
                    stall_raw = 1'b1;
                    cnt_en    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_lat_q    <= '0;
            rd_en_lat_q <= 1'b0;
            mtr_lat_q   <= 1'b0;
            rw_lat_q    <= 1'b0;
            rdata_q     <= '0;
            alu_q       <= '0;
            rd_out_q    <= '0;
            mtr_out_q   <= 1'b0;
            rw_out_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_lat_q    <= rd_lat_d;
            rd_en_lat_q <= rd_en_lat_d;
            mtr_lat_q   <= mtr_lat_d;
            rw_lat_q    <= rw_lat_d;
            rdata_q     <= rdata_d;
            alu_q       <= alu_d;
            rd_out_q    <= rd_out_d;
            mtr_out_q   <= mtr_out_d;
            rw_out_q    <= rw_out_d;
            err_q       <= err_d;
        end
    end

    // Stall is combinational, so it must be forced low while reset is held.
    assign stall          = reset & stall_raw;
    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign read_data_out  = rdata_q;
    assign alu_result_out = alu_q;
    assign rd_out         = rd_out_q;
    assign mem_to_reg_out = mtr_out_q;
    assign reg_write_out  = rw_out_q;
    assign mem_err_out    = err_q;

endmodule

// File: tb/tb_dm_wb_stage.sv
// Directed bench for dm_wb_stage: vector table for single-cycle ops plus
// hand-written load/store/timeout/reset/misalign sequences (TIMEOUT_CYCLES=4).
module tb_dm_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
    logic [4:0]  rd_in;
    logic [31:0] mem_address_in, write_data_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] read_data_out, alu_result_out;
    logic [4:0]  rd_out;
    logic        mem_to_reg_out, reg_write_out, mem_err_out;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    dm_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .mem_to_reg_in  (mem_to_reg_in),
        .reg_write_in   (reg_write_in),
        .rd_in          (rd_in),
        .mem_address_in (mem_address_in),
        .write_data_in  (write_data_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .stall          (stall),
        .read_data_out  (read_data_out),
        .alu_result_out (alu_result_out),
        .rd_out         (rd_out),
        .mem_to_reg_out (mem_to_reg_out),
        .reg_write_out  (reg_write_out),
        .mem_err_out    (mem_err_out)
    );

    typedef struct {
        logic        rd_en, wr_en, mtr, rw;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic        exp_err, exp_rw;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic mtr, input logic rw,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] wd);
        mem_read_in    = r;
        mem_write_in   = w;
        mem_to_reg_in  = mtr;
        reg_write_in   = rw;
        rd_in          = rd;
        mem_address_in = a;
        write_data_in  = wd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stall_cnt, req_cnt, err_cnt, rw_bad;
        logic prev_stall;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  32'h0000_0010, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd31, 32'hCAFE_0000, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd3,  32'h0000_0044, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b1};

        reset      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        #3;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_rw", 32'(reg_write_out), 32'h0);
        chk("rst_err", 32'(mem_err_out), 32'h0);
        chk("rst_alu", alu_result_out, 32'h0);
        #9 reset = 1'b1;
        tick;

        // Single-cycle retires: plain ALU ops and the illegal read+write combination.
        for (int i = 0; i < 4; i++) begin
            drive(vecs[i].rd_en, vecs[i].wr_en, vecs[i].mtr, vecs[i].rw, vecs[i].rd,
                  vecs[i].addr, 32'h5555_AAAA);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'h0);
            tick;
            chk($sformatf("v%0d_alu", i), alu_result_out, vecs[i].addr);
            chk($sformatf("v%0d_rd", i), 32'(rd_out), 32'(vecs[i].rd));
            chk($sformatf("v%0d_mtr", i), 32'(mem_to_reg_out), 32'(vecs[i].mtr));
            chk($sformatf("v%0d_rw", i), 32'(reg_write_out), 32'(vecs[i].exp_rw));
            chk($sformatf("v%0d_err", i), 32'(mem_err_out), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'h0);
            chk($sformatf("v%0d_rdata", i), read_data_out, 32'h0);
        end

        // Load with ack in the 4th ACCESS cycle (coincides with the timeout boundary).
        stall_cnt = 0;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h0000_0100, 32'h0);
        #1;
        if (stall) stall_cnt++;
        for (int c = 1; c <= 4; c++) begin
            tick;
            if (c == 4) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'hDEAD_BEEF;
            end
            #1;
            if (c == 1) begin
                chk("ld_req", 32'(dmem_req), 32'h1);
                chk("ld_we", 32'(dmem_we), 32'h0);
                chk("ld_addr", dmem_addr, 32'h0000_0100);
                chk("ld_bubble_rw", 32'(reg_write_out), 32'h0);
            end
            if (stall) stall_cnt++;
        end
        tick;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        chk("ld_stall_cycles", 32'(stall_cnt), 32'd4);
        chk("ld_rdata", read_data_out, 32'hDEAD_BEEF);
        chk("ld_rw", 32'(reg_write_out), 32'h1);
        chk("ld_rd", 32'(rd_out), 32'd7);
        chk("ld_err", 32'(mem_err_out), 32'h0);
        chk("ld_req_drop", 32'(dmem_req), 32'h0);

        // Store with single-cycle memory latency (ack in the 2nd ACCESS cycle).
        stall_cnt = 0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_0200, 32'h0000_1234);
        #1;
        if (stall) stall_cnt++;
        tick;
        chk("st_req", 32'(dmem_req), 32'h1);
        chk("st_we", 32'(dmem_we), 32'h1);
        chk("st_wdata", dmem_wdata, 32'h0000_1234);
        chk("st_addr", dmem_addr, 32'h0000_0200);
        if (stall) stall_cnt++;
        tick;
        dmem_ack = 1'b1;
        #1;
        if (stall) stall_cnt++;
        tick;
        dmem_ack = 1'b0;
        // Next op is a plain ALU op with a stray ack, which must be ignored in IDLE.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0000_0077, 32'h0);
        #1;
        chk("st_stall_cycles", 32'(stall_cnt), 32'd2);
        chk("st_rw", 32'(reg_write_out), 32'h0);
        chk("st_rdata", read_data_out, 32'h0);
        chk("st_err", 32'(mem_err_out), 32'h0);
        dmem_ack = 1'b1;
        tick;
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        chk("idle_ack_req", 32'(dmem_req), 32'h0);
        chk("idle_ack_rw", 32'(reg_write_out), 32'h1);
        chk("idle_ack_alu", alu_result_out, 32'h0000_0077);

        // Load that never gets an ack: expect 4 request cycles then one error pulse.
        req_cnt = 0; err_cnt = 0; rw_bad = 0; prev_stall = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0300, 32'h0);
        for (int c = 0; c < 10; c++) begin
            tick;
            if (!prev_stall) drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
            #1;
            if (dmem_req) req_cnt++;
            if (mem_err_out) err_cnt++;
            if (reg_write_out) rw_bad++;
            prev_stall = stall;
        end
        chk("to_req_cycles", 32'(req_cnt), 32'd4);
        chk("to_err_pulses", 32'(err_cnt), 32'd1);
        chk("to_rw_never", 32'(rw_bad), 32'd0);

        // Reset mid-ACCESS: outputs clear immediately, nothing retires afterwards.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 32'h0000_0400, 32'h0);
        tick;
        chk("rs_req_before", 32'(dmem_req), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("rs_req_async", 32'(dmem_req), 32'h0);
        chk("rs_stall_async", 32'(stall), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick;
        #2 reset = 1'b1;
        err_cnt = 0; rw_bad = 0; req_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick;
            dmem_ack = (c == 0);
            #1;
            if (mem_err_out) err_cnt++;
            if (reg_write_out) rw_bad++;
            if (dmem_req) req_cnt++;
        end
        dmem_ack = 1'b0;
        chk("rs_no_err", 32'(err_cnt), 32'd0);
        chk("rs_no_retire", 32'(rw_bad), 32'd0);
        chk("rs_no_req", 32'(req_cnt), 32'd0);

        // Misaligned load at 0x102.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h0000_0102, 32'h0);
        #1;
`ifdef DM_MISALIGN_CHECK_EN
        chk("ma_stall", 32'(stall), 32'h0);
        tick;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        chk("ma_req", 32'(dmem_req), 32'h0);
        chk("ma_err", 32'(mem_err_out), 32'h1);
        chk("ma_rw", 32'(reg_write_out), 32'h0);
        tick;
        chk("ma_err_pulse", 32'(mem_err_out), 32'h0);
`else
        chk("ma_stall", 32'(stall), 32'h1);
        tick;
        chk("ma_req", 32'(dmem_req), 32'h1);
        chk("ma_addr", dmem_addr, 32'h0000_0102);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0BAD_F00D;
        tick;
        dmem_ack   = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        chk("ma_rdata", read_data_out, 32'h0BAD_F00D);
        chk("ma_err", 32'(mem_err_out), 32'h0);
        chk("ma_rw", 32'(reg_write_out), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
